axi_tmp_regbank: RTL and testbench
==================================

# axi_tmp_regbank

AXI4-Lite slave register bank that generalises the fixed four-register AXI_TMP peripheral: parametrised data width, register count and address width, byte-strobe writes, per-register read-only status inputs, and SLVERR on out-of-range access. It sits behind the PS or master VIP AXI interconnect port. It exports the writable register contents to fabric logic and imports status words from fabric logic.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus and register width; 32 or 64 only.
- C_NUM_REGS, 4, register count; power of two, 2..64.
- C_S_AXI_ADDR_WIDTH, 6, byte-address width; must be ≥ log2(C_NUM_REGS)+log2(DW/8).
- C_RO_MASK, 0, C_NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from status_in.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  AW/3/1/1  write address channel; PROT ignored.
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  DW/DW/8/1/1  write data channel.
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response.
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  AW/3/1/1  read address; PROT ignored.
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  DW/2/1/1  read data.
- reg_out  out  C_NUM_REGS*DW  flattened writable register contents; register i at [i*DW +: DW].
- status_in  in  C_NUM_REGS*DW  read-only sources; only slices with C_RO_MASK bit set are used.
- wr_pulse  out  C_NUM_REGS  per-register write strobe; present only with the macro described under Configuration.

## Operation
- Register index = addr[log2(DW/8) +: log2(C_NUM_REGS)]. Low log2(DW/8) bits are ignored. Any set address bit above the index field is out of range.
- Write commit:
  - In range, writable: only bytes with WSTRB=1 are updated; BRESP=OKAY (2'b00). WSTRB=0 gives OKAY with no change.
  - Out-of-range or read-only target: no state change; BRESP=SLVERR (2'b10).
- Read:
  - In range: RDATA is the register value, or the status_in slice for a read-only index; RRESP=OKAY.
  - Out of range: RDATA=0, RRESP=SLVERR.
- Write FSM states: W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP.
  - AWREADY is high in W_IDLE and W_WAIT_ADDR.
  - WREADY is high in W_IDLE and W_WAIT_DATA.
  - AW alone → W_WAIT_DATA (address latched). W alone → W_WAIT_ADDR (data and strobe latched). Both in the same cycle, or the second one arriving → commit on that edge, then W_RESP.
  - W_RESP holds BVALID until BREADY, then → W_IDLE.
- Read FSM states: R_IDLE, R_RESP.
  - ARREADY is high in R_IDLE. On the AR handshake, RDATA/RRESP are registered and the FSM moves to R_RESP.
  - R_RESP holds until RREADY, then → R_IDLE.
- Read and write FSMs are independent and may be active at the same time.

## Timing
- Reset (async assert): all registers 0; both FSMs idle; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; wr_pulse=0.
- Readies after reset: AWREADY, WREADY and ARREADY are 0 while reset is asserted and stay 0 until the first rising edge after deassertion (rst_done flop). They may be high from the following cycle.
- Write latency: BVALID rises one cycle after the commit edge; reg_out shows the new value in that same cycle.
- Write throughput: at most one write per 2 cycles, since there is no AW/W acceptance in W_RESP.
- Read latency: RVALID rises one cycle after the AR handshake. status_in is sampled at the handshake edge.
- RDATA/RRESP and BRESP are stable while VALID is high and READY is low.
- Write commit and AR handshake on the same edge, same register: the read returns the pre-write value.
- Reset asserted mid-transaction: the transaction is dropped and no response is issued; a partially latched AW or W is discarded.

## Configuration
- AXI_TMP_REGBANK_WR_PULSE_EN defined:
  - wr_pulse port exists.
  - Bit i is high for exactly one cycle, the cycle after an OKAY commit to register i with a nonzero WSTRB, aligned with the reg_out update.
  - Never pulses for SLVERR writes or WSTRB=0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package axi_tmp_pkg:
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Write-state enum (W_IDLE..W_RESP) and read-state enum (R_IDLE, R_RESP).
  - Function computing the index LSB from the data width.
- Sub-module axi_tmp_reg_cell, generated per register:
  - Byte-strobe merge and write enable.
  - Read-only selection between stored value and status_in.
  - wr_pulse flop under the macro.

## Test plan
- Default params, after reset: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back → each BRESP=OKAY; reads return 0x1..0x4 with RRESP=OKAY; RVALID one cycle after ARREADY handshake.
- Write 0xAABBCCDD then 0x11223344 with WSTRB=4'b0101 to 0x4 → read returns 0xAA22CC44.
- AW presented 3 cycles before W, and separately W 3 cycles before AW → both commit; BVALID one cycle after the second handshake; BREADY held low 5 cycles keeps BVALID and BRESP stable.
- Write to 0x20 and read of 0x24 (out of range at C_S_AXI_ADDR_WIDTH=6) → BRESP=SLVERR; RRESP=SLVERR with RDATA=0; no register changed.
- C_RO_MASK=4'b0010, status_in slice 1 = 0xDEADBEEF: write 0x5 to 0x4 → SLVERR; read 0x4 → 0xDEADBEEF.
- Reset pulsed while in W_WAIT_DATA, then a full write to 0x0 → no BVALID from the aborted write; new write OKAY; reg_out slice 0 correct. With AXI_TMP_REGBANK_WR_PULSE_EN, wr_pulse[0] is high for exactly one cycle.

Source files
------------

// File: rtl/axi_tmp_pkg.sv
// axi_tmp_pkg: shared response codes, FSM state types and address helpers
// for the axi_tmp_regbank AXI4-Lite register bank.
package axi_tmp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_DATA,
        W_WAIT_ADDR,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_t;

    // Byte-lane bits below the register index: 2 for 32-bit, 3 for 64-bit.
    function automatic int idx_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi_tmp_reg_cell.sv
// axi_tmp_reg_cell: one register of the bank. Holds the byte-strobe merged
// value for writable registers; read-only cells present status_in instead.
// With AXI_TMP_REGBANK_WR_PULSE_EN defined, also emits a one-cycle wr_pulse
// aligned with the stored value update.
module axi_tmp_reg_cell
    import axi_tmp_pkg::*;
#(
    parameter int DW = 32,
    parameter bit RO = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic [DW-1:0]   status_in,
    output logic [DW-1:0]   reg_q,
    output logic [DW-1:0]   rd_val
`ifdef AXI_TMP_REGBANK_WR_PULSE_EN
    ,
    output logic            wr_pulse
`endif
);

    // Byte-strobe merge into the stored word; read-only cells never store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q <= '0;
        end else if (wr_en && !RO) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (wstrb[b]) begin
                    reg_q[b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rd_val = RO ? status_in : reg_q;

`ifdef AXI_TMP_REGBANK_WR_PULSE_EN
    // Single-cycle strobe for a real (nonzero strobe) commit to this register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pulse <= 1'b0;
        end else begin
            wr_pulse <= wr_en && !RO && (|wstrb);
        end
    end
`endif

endmodule

// File: rtl/axi_tmp_regbank.sv
// axi_tmp_regbank: AXI4-Lite slave register bank with byte-strobe writes,
// read-only status registers (C_RO_MASK) and SLVERR on out-of-range access.
// Define AXI_TMP_REGBANK_WR_PULSE_EN to add the per-register wr_pulse output.
//
// state       | meaning
// W_IDLE      | ready for AW and W together or either alone
// W_WAIT_DATA | address latched, waiting for W
// W_WAIT_ADDR | data/strobe latched, waiting for AW
// W_RESP      | write committed, BVALID held until BREADY
// R_IDLE      | ready for AR
// R_RESP      | RDATA/RRESP registered, RVALID held until RREADY
module axi_tmp_regbank
    import axi_tmp_pkg::*;
#(
    parameter int                    C_S_AXI_DATA_WIDTH = 32,
    parameter int                    C_NUM_REGS         = 4,
    parameter int                    C_S_AXI_ADDR_WIDTH = 6,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK          = '0
) (
    input  logic                                       S_AXI_ACLK,
    input  logic                                       S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
    input  logic [2:0]                                 S_AXI_AWPROT,
    input  logic                                       S_AXI_AWVALID,
    output logic                                       S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
    input  logic                                       S_AXI_WVALID,
    output logic                                       S_AXI_WREADY,
    output logic [1:0]                                 S_AXI_BRESP,
    output logic                                       S_AXI_BVALID,
    input  logic                                       S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
    input  logic [2:0]                                 S_AXI_ARPROT,
    input  logic                                       S_AXI_ARVALID,
    output logic                                       S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
    output logic [1:0]                                 S_AXI_RRESP,
    output logic                                       S_AXI_RVALID,
    input  logic                                       S_AXI_RREADY,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
    input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   status_in
`ifdef AXI_TMP_REGBANK_WR_PULSE_EN
    ,
    output logic [C_NUM_REGS-1:0]                      wr_pulse
`endif
);

    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int SW  = DW / 8;
    localparam int LSB = idx_lsb(DW);
    localparam int IW  = $clog2(C_NUM_REGS);
    localparam int TOP = LSB + IW;

    wstate_t                       wstate_q, wstate_d;
    rstate_t                       rstate_q, rstate_d;
    logic                          rst_done;
    logic                          aw_hs, w_hs, ar_hs, commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, cur_awaddr;
    logic [DW-1:0]                 wdata_q, cur_wdata;
    logic [SW-1:0]                 wstrb_q, cur_wstrb;
    logic [IW-1:0]                 widx, ridx;
    logic                          w_in_range, r_in_range, wr_ok;
    logic [DW-1:0]                 rd_val [C_NUM_REGS];
    logic                          unused_ok;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // The half arriving this cycle is used directly; the other comes from the latch.
    assign cur_awaddr = aw_hs ? S_AXI_AWADDR : awaddr_q;
    assign cur_wdata  = w_hs ? S_AXI_WDATA : wdata_q;
    assign cur_wstrb  = w_hs ? S_AXI_WSTRB : wstrb_q;

    assign widx       = cur_awaddr[LSB +: IW];
    assign ridx       = S_AXI_ARADDR[LSB +: IW];
    assign w_in_range = (cur_awaddr >> TOP) == '0;
    assign r_in_range = (S_AXI_ARADDR >> TOP) == '0;
    assign commit     = (wstate_d == W_RESP) && (wstate_q != W_RESP);
    assign wr_ok      = commit && w_in_range && !C_RO_MASK[widx];

    // PROT and the byte-lane address bits carry no meaning for this bank.
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         cur_awaddr[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

    // Readies stay low until the first clock edge after reset release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) rst_done <= 1'b0;
        else                rst_done <= 1'b1;
    end

    // Write and read state registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
        end
    end

    // Write next-state: commit when the second of AW/W is accepted.
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) wstate_d = W_RESP;
                else if (aw_hs)    wstate_d = W_WAIT_DATA;
                else if (w_hs)     wstate_d = W_WAIT_ADDR;
            end
            W_WAIT_DATA: if (w_hs)         wstate_d = W_RESP;
            W_WAIT_ADDR: if (aw_hs)        wstate_d = W_RESP;
            W_RESP:      if (S_AXI_BREADY) wstate_d = W_IDLE;
            default:                       wstate_d = W_IDLE;
        endcase
    end

    // Write channel handshake outputs.
    always_comb begin
        S_AXI_AWREADY = rst_done && ((wstate_q == W_IDLE) || (wstate_q == W_WAIT_ADDR));
        S_AXI_WREADY  = rst_done && ((wstate_q == W_IDLE) || (wstate_q == W_WAIT_DATA));
        S_AXI_BVALID  = (wstate_q == W_RESP);
    end

    // Read next-state.
    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (ar_hs)         rstate_d = R_RESP;
            R_RESP:  if (S_AXI_RREADY)  rstate_d = R_IDLE;
            default:                    rstate_d = R_IDLE;
        endcase
    end

    // Read channel handshake outputs.
    always_comb begin
        S_AXI_ARREADY = rst_done && (rstate_q == R_IDLE);
        S_AXI_RVALID  = (rstate_q == R_RESP);
    end

    // Latch partial write halves, the write response and the read response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            S_AXI_BRESP <= RESP_OKAY;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
        end else begin
            if (aw_hs) awaddr_q <= S_AXI_AWADDR;
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (commit) S_AXI_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (ar_hs) begin
                S_AXI_RDATA <= r_in_range ? rd_val[ridx] : '0;
                S_AXI_RRESP <= r_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
        axi_tmp_reg_cell #(
            .DW (DW),
            .RO (C_RO_MASK[i])
        ) u_cell (
            .clk       (S_AXI_ACLK),
            .rst_n     (S_AXI_ARESETN),
            .wr_en     (wr_ok && (widx == IW'(i))),
            .wdata     (cur_wdata),
            .wstrb     (cur_wstrb),
            .status_in (status_in[i*DW +: DW]),
            .reg_q     (reg_out[i*DW +: DW]),
            .rd_val    (rd_val[i])
`ifdef AXI_TMP_REGBANK_WR_PULSE_EN
            ,
            .wr_pulse  (wr_pulse[i])
`endif
        );
    end

endmodule

// File: tb/tb_axi_tmp_regbank.sv
// Bench for axi_tmp_regbank: directed scenarios plus randomized traffic
// against a word-array model of the register bank.
`timescale 1ns/1ps
module tb_axi_tmp_regbank;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int AW = 6;
    localparam int SPAN = NR * (DW / 8);
    localparam logic [NR-1:0] RO_MASK = 4'b0010;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     AWADDR = '0, ARADDR = '0;
    logic [2:0]        AWPROT = '0, ARPROT = '0;
    logic              AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic              AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [DW-1:0]     WDATA = '0, RDATA;
    logic [DW/8-1:0]   WSTRB = '0;
    logic [1:0]        BRESP, RRESP;
    logic [NR*DW-1:0]  reg_out;
    logic [NR*DW-1:0]  status_in;
`ifdef AXI_TMP_REGBANK_WR_PULSE_EN
    logic [NR-1:0]     wr_pulse;
`endif

    logic [DW-1:0] mdl  [NR];
    logic [DW-1:0] stat [NR];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign status_in = {stat[3], stat[2], stat[1], stat[0]};

    axi_tmp_regbank #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_NUM_REGS         (NR),
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_RO_MASK          (RO_MASK)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (AWADDR),
        .S_AXI_AWPROT  (AWPROT),
        .S_AXI_AWVALID (AWVALID),
        .S_AXI_AWREADY (AWREADY),
        .S_AXI_WDATA   (WDATA),
        .S_AXI_WSTRB   (WSTRB),
        .S_AXI_WVALID  (WVALID),
        .S_AXI_WREADY  (WREADY),
        .S_AXI_BRESP   (BRESP),
        .S_AXI_BVALID  (BVALID),
        .S_AXI_BREADY  (BREADY),
        .S_AXI_ARADDR  (ARADDR),
        .S_AXI_ARPROT  (ARPROT),
        .S_AXI_ARVALID (ARVALID),
        .S_AXI_ARREADY (ARREADY),
        .S_AXI_RDATA   (RDATA),
        .S_AXI_RRESP   (RRESP),
        .S_AXI_RVALID  (RVALID),
        .S_AXI_RREADY  (RREADY),
        .reg_out       (reg_out),
        .status_in     (status_in)
`ifdef AXI_TMP_REGBANK_WR_PULSE_EN
        ,
        .wr_pulse      (wr_pulse)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Model: byte address -> word index; anything at or beyond SPAN is out of range.
    function automatic logic [1:0] model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                               input logic [DW/8-1:0] strb);
        int idx;
        if (int'(addr) >= SPAN) return 2'b10;
        idx = int'(addr) / (DW / 8);
        if (RO_MASK[idx]) return 2'b10;
        for (int b = 0; b < DW / 8; b++)
            if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
        return 2'b00;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            check($sformatf("%s_reg_out%0d", tag, i), reg_out[i*DW +: DW], mdl[i]);
    endtask

    // skew > 0: AW leads W by skew cycles; skew < 0: W leads AW.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [DW/8-1:0] strb, input int skew, input int bhold);
        logic [1:0]    exp_resp;
        logic [NR-1:0] exp_pulse;
        int  c = 0;
        int  a_start = (skew < 0) ? -skew : 0;
        int  w_start = (skew > 0) ? skew : 0;
        bit  aw_done = 0, w_done = 0, aw_now, w_now;
        exp_resp  = model_write(addr, data, strb);
        exp_pulse = (exp_resp == 2'b00 && strb != 0) ? (NR'(1) << (int'(addr) / (DW / 8))) : '0;
        while (!(aw_done && w_done) && c < 40) begin
            AWVALID = !aw_done && (c >= a_start);
            AWADDR  = addr;
            WVALID  = !w_done && (c >= w_start);
            WDATA   = data;
            WSTRB   = strb;
            aw_now  = AWVALID && AWREADY;
            w_now   = WVALID && WREADY;
            @(posedge clk); #1;
            aw_done = aw_done || aw_now;
            w_done  = w_done || w_now;
            c++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        if (!(aw_done && w_done)) check("wr_timeout", c, 0);
        check("bvalid_lat", BVALID, 1);
        check("bresp", BRESP, exp_resp);
        check_regs("wr");
`ifdef AXI_TMP_REGBANK_WR_PULSE_EN
        check("wr_pulse", wr_pulse, exp_pulse);
`endif
        for (int k = 0; k < bhold; k++) begin
            @(posedge clk); #1;
            check("bvalid_hold", BVALID, 1);
            check("bresp_hold", BRESP, exp_resp);
`ifdef AXI_TMP_REGBANK_WR_PULSE_EN
            check("wr_pulse_clr", wr_pulse, 0);
`endif
        end
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
        check("bvalid_clr", BVALID, 0);
`ifdef AXI_TMP_REGBANK_WR_PULSE_EN
        check("wr_pulse_end", wr_pulse, 0);
`endif
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int rhold);
        logic [DW-1:0] exp_d;
        logic [1:0]    exp_r;
        int idx;
        int c = 0;
        bit done = 0;
        if (int'(addr) >= SPAN) begin
            exp_d = '0;
            exp_r = 2'b10;
        end else begin
            idx   = int'(addr) / (DW / 8);
            exp_d = RO_MASK[idx] ? stat[idx] : mdl[idx];
            exp_r = 2'b00;
        end
        ARADDR  = addr;
        ARVALID = 1'b1;
        while (!done && c < 40) begin
            done = ARREADY;
            @(posedge clk); #1;
            c++;
        end
        ARVALID = 1'b0;
        if (!done) check("rd_timeout", c, 0);
        check("rvalid_lat", RVALID, 1);
        check("rdata", RDATA, exp_d);
        check("rresp", RRESP, exp_r);
        for (int k = 0; k < rhold; k++) begin
            @(posedge clk); #1;
            check("rdata_hold", RDATA, exp_d);
            check("rresp_hold", RRESP, exp_r);
        end
        RREADY = 1'b1;
        @(posedge clk); #1;
        RREADY = 1'b0;
        check("rvalid_clr", RVALID, 0);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] old_v;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        stat[0] = 32'h0BAD0000;
        stat[1] = 32'hDEADBEEF;
        stat[2] = 32'h0BAD0002;
        stat[3] = 32'h0BAD0003;

        // Reset state and ready release timing.
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", AWREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_bresp", BRESP, 0);
`ifdef AXI_TMP_REGBANK_WR_PULSE_EN
        check("rst_wr_pulse", wr_pulse, 0);
`endif
        check_regs("rst");
        #2 rst_n = 1'b1;
        #1;
        check("pre_edge_wready", WREADY, 0);
        @(posedge clk); #1;
        check("post_edge_awready", AWREADY, 1);
        check("post_edge_wready", WREADY, 1);
        check("post_edge_arready", ARREADY, 1);

        // Basic fill and readback (register 1 is read-only).
        for (int i = 0; i < NR; i++) do_write(AW'(i * 4), DW'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < NR; i++) do_read(AW'(i * 4), 0);

        // Byte strobes.
        do_write(6'h08, 32'hAABBCCDD, 4'hF, 0, 0);
        do_write(6'h08, 32'h11223344, 4'b0101, 0, 0);
        do_read(6'h08, 0);
        check("strobe_merge", mdl[2], 32'hAA22CC44);
        do_write(6'h08, 32'hFFFFFFFF, 4'b0000, 0, 0);

        // Skewed address/data with BREADY held off.
        do_write(6'h00, 32'hCAFE0001, 4'hF, 3, 5);
        do_write(6'h0C, 32'hCAFE0003, 4'hF, -3, 5);

        // Out of range and read-only.
        do_write(6'h20, 32'h12345678, 4'hF, 0, 0);
        do_read(6'h24, 2);
        do_write(6'h04, 32'h00000005, 4'hF, 0, 0);
        do_read(6'h04, 1);

        // Write commit and read handshake on the same edge: read sees old value.
        old_v   = mdl[2];
        AWADDR  = 6'h08; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF;
        ARADDR  = 6'h08;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("same_edge_bresp", model_write(6'h08, 32'h5A5A5A5A, 4'hF), 2'b00);
        check("same_edge_rvalid", RVALID, 1);
        check("same_edge_bvalid", BVALID, 1);
        check("same_edge_rdata", RDATA, old_v);
        check_regs("same_edge");
        BREADY = 1'b1; RREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0; RREADY = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, 63));
            else                          a = AW'($urandom_range(0, SPAN - 1));
            if ($urandom_range(0, 1) == 0)
                do_write(a, DW'($urandom), 4'($urandom_range(0, 15)),
                         $urandom_range(0, 6) - 3, $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end

        // Reset while a write is waiting for its data.
        AWADDR  = 6'h00;
        AWVALID = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0;
        check("abort_no_bvalid", BVALID, 0);
        check("abort_wready", WREADY, 1);
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        #1;
        check("abort_rst_awready", AWREADY, 0);
        check_regs("abort_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_bvalid_quiet", BVALID, 0);
        end
        do_write(6'h00, 32'h600DF00D, 4'hF, 0, 0);
        do_read(6'h00, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
